// File: rtl/leaf_group_rr_arbiter.sv
// leaf_group_rr_arbiter: round-robin one-hot grant for the leaves of a branch node.
// Optional grant watchdog is compiled in by defining LEAF_ARB_WATCHDOG_EN.
module leaf_group_rr_arbiter #(
    parameter int N_REQ    = 10,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     freeze,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     timeout_pulse
);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [HW-1:0]    hold_cnt;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] elig;
    logic [IW-1:0]    win;
    logic             win_ok;
    logic [IW:0]      idx;
    logic [IW-1:0]    next_ptr;
    logic             owner_req;

    assign elig      = req & ~mask;
    assign owner_req = req[gnt_id];
    assign next_ptr  = (gnt_id == LAST) ? '0 : gnt_id + IW'(1);

    // first eligible index scanning ptr upward with wrap
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N_REQ))
                idx = idx - (IW+1)'(N_REQ);
            if (!win_ok && elig[idx[IW-1:0]]) begin
                win_ok = 1'b1;
                win    = idx[IW-1:0];
            end
        end
    end

`ifndef LEAF_ARB_WATCHDOG_EN
    assign mask          = '0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
`ifdef LEAF_ARB_WATCHDOG_EN
            mask          <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef LEAF_ARB_WATCHDOG_EN
            timeout_pulse <= 1'b0;
            mask          <= mask & req;
`endif
            unique case (state)
                IDLE: begin
                    if (!freeze && win_ok) begin
                        state     <= GRANT;
                        gnt       <= N_REQ'(1) << win;
                        gnt_valid <= 1'b1;
                        gnt_id    <= win;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                        ptr       <= next_ptr;
                    end
`ifdef LEAF_ARB_WATCHDOG_EN
                    else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                        state         <= IDLE;
                        gnt           <= '0;
                        gnt_valid     <= 1'b0;
                        gnt_id        <= '0;
                        ptr           <= next_ptr;
                        timeout_pulse <= 1'b1;
                        mask[gnt_id]  <= 1'b1;
                    end
`endif
                    else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_group_rr_arbiter.sv
// tb_leaf_group_rr_arbiter: scoreboard bench for the leaf group round-robin arbiter.
// Watchdog expectations follow LEAF_ARB_WATCHDOG_EN.
module tb_leaf_group_rr_arbiter;
    logic       clk;
    logic       rst_n;
    logic [9:0] req;
    logic       freeze;
    logic [9:0] gnt;
    logic       gnt_valid;
    logic [3:0] gnt_id;
    logic       timeout_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    leaf_group_rr_arbiter #(.N_REQ(10), .MAX_HOLD(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .freeze(freeze),
        .gnt(gnt),
        .gnt_valid(gnt_valid),
        .gnt_id(gnt_id),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {timeout_pulse, gnt_valid, gnt_id, gnt} for a grant vector
    function automatic logic [15:0] mk(logic p, logic [9:0] g);
        logic [3:0] id;
        id = '0;
        for (int i = 0; i < 10; i++)
            if (g[i]) id = 4'(i);
        return {p, |g, id, g};
    endfunction

    function automatic logic [15:0] obs();
        return {timeout_pulse, gnt_valid, gnt_id, gnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req    = '0;
        freeze = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] e, o;
        apply_reset();
        n_tests++;
        if (obs() !== mk(1'b0, 10'h000)) begin
            n_fail++;
            $display("FAIL reset_state: got %h exp %h", obs(), mk(1'b0, 10'h000));
        end
        req = 10'h010;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(mk(1'b0, 10'h010));
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_pre_grant: got %h exp %h", o, e);
            end
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs() !== mk(1'b0, 10'h000)) begin
            n_fail++;
            $display("FAIL reset_async: got %h exp %h", obs(), mk(1'b0, 10'h000));
        end
        req = '0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        req = 10'h001;
        exp_q.push_back(mk(1'b0, 10'h001));
        tick();
        req = 10'h000;
        exp_q.push_back(mk(1'b0, 10'h000));
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_regrant: got %h exp %h", obs(), e);
        end
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_release: got %h exp %h", obs(), e);
        end
    endtask

    task automatic test_single();
        logic [15:0] e, o;
        apply_reset();
        for (int c = 0; c <= 5; c++) begin
            req = (c < 5) ? 10'h008 : 10'h000;
            exp_q.push_back(mk(1'b0, (c + 1 <= 5) ? 10'h008 : 10'h000));
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single c%0d: got %h exp %h", c + 1, o, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] e, o;
        logic [9:0]  r, g;
        int d;
        apply_reset();
        for (int c = 0; c <= 33; c++) begin
            r = 10'h3FF;
            if (c % 3 == 2)
                r = r & ~(10'(1) << ((c / 3) % 10));
            if (c == 33)
                r = 10'h000;
            d = c + 1;
            g = (d % 3 == 0 || d == 34) ? 10'h000 : 10'(1) << ((d / 3) % 10);
            req = r;
            exp_q.push_back(mk(1'b0, g));
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL round_robin c%0d: got %h exp %h", d, o, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] e, o;
        logic [9:0] rq [6];
        logic [9:0] ex [6];
        rq = '{10'h100, 10'h000, 10'h201, 10'h021, 10'h021, 10'h000};
        ex = '{10'h100, 10'h000, 10'h200, 10'h000, 10'h001, 10'h000};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            req = rq[c];
            exp_q.push_back(mk(1'b0, ex[c]));
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap c%0d: got %h exp %h", c + 1, o, e);
            end
        end
    endtask

    task automatic test_freeze();
        logic [15:0] e, o;
        apply_reset();
        for (int c = 0; c <= 6; c++) begin
            req    = (c < 6) ? 10'h010 : 10'h000;
            freeze = (c < 4 || c == 5);
            exp_q.push_back(mk(1'b0, (c == 4 || c == 5) ? 10'h010 : 10'h000));
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL freeze c%0d: got %h exp %h", c + 1, o, e);
            end
        end
        freeze = 1'b0;
    endtask

    function automatic logic [9:0] wd_req(int c);
`ifdef LEAF_ARB_WATCHDOG_EN
        if (c <= 18) return 10'h024;
        if (c <= 23) return 10'h004;
        if (c == 25) return 10'h004;
        return 10'h000;
`else
        if (c <= 24) return 10'h024;
        if (c == 25) return 10'h020;
        return 10'h000;
`endif
    endfunction

    function automatic logic [15:0] wd_exp(int d);
`ifdef LEAF_ARB_WATCHDOG_EN
        if (d <= 16) return mk(1'b0, 10'h004);
        if (d == 17) return mk(1'b1, 10'h000);
        if (d <= 19) return mk(1'b0, 10'h020);
        if (d == 26) return mk(1'b0, 10'h004);
        return mk(1'b0, 10'h000);
`else
        if (d <= 25) return mk(1'b0, 10'h004);
        return mk(1'b0, 10'h000);
`endif
    endfunction

    task automatic test_watchdog();
        logic [15:0] e, o;
        apply_reset();
        for (int c = 0; c <= 26; c++) begin
            req = wd_req(c);
            exp_q.push_back(wd_exp(c + 1));
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL watchdog c%0d: got %h exp %h", c + 1, o, e);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        freeze = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_freeze();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
